// File: rtl/snake_step_timer.sv
// ---------------------------------------------------------------------------
// snake_step_timer
//
// Turns the slow divided clock (kindaSlowClk, ~250 Hz) into a game step pulse
// inside the clk50Mhz domain. The slow clock is synchronised, edge detected
// into single-cycle ticks, and the ticks are counted into a step pulse whose
// period shrinks as the speed level rises. Keyboard-decoded pulses control the
// run/pause/restart behaviour.
//
// Ports
//   clk50Mhz     in   1        system clock
//   reset        in   1        asynchronous, active-high reset
//   slowClkIn    in   1        divided clock, asynchronous to clk50Mhz
//   start        in   1        1-cycle pulse: (re)start game timing
//   pauseToggle  in   1        1-cycle pulse: toggle RUN/PAUSE
//   speedUp      in   1        1-cycle pulse: level+1, saturating
//   tickStrobe   out  1        1-cycle pulse per slowClkIn rising edge
//   step         out  1        1-cycle game step pulse
//   level        out  LEVEL_W  current speed level
//   running      out  1        timer is in RUN
//   paused       out  1        timer is in PAUSE
//   wdErr        out  1        sticky watchdog error
//
// Build option
//   STEP_WATCHDOG_EN : when defined, a watchdog counts clk50Mhz cycles since
//   the last tick (or start). After WD_CYCLES cycles without a tick wdErr is
//   set and stays set until reset or start; no step is issued while it is set.
//   When undefined, there is no watchdog and wdErr is tied low.
// ---------------------------------------------------------------------------
module snake_step_timer #(
  parameter int BASE_TICKS = 50,      // ticks per step at level 0
  parameter int DEC_TICKS  = 5,       // ticks removed per speed level
  parameter int MIN_TICKS  = 10,      // floor on ticks per step
  parameter int MAX_LEVEL  = 7,       // level saturation value
  parameter int LEVEL_W    = 3,       // width of level
  parameter int CNT_W      = 8,       // width of tick counter
  parameter int WD_CYCLES  = 400000   // watchdog limit in clk50Mhz cycles
) (
  input  logic               clk50Mhz,
  input  logic               reset,
  input  logic               slowClkIn,
  input  logic               start,
  input  logic               pauseToggle,
  input  logic               speedUp,
  output logic               tickStrobe,
  output logic               step,
  output logic [LEVEL_W-1:0] level,
  output logic               running,
  output logic               paused,
  output logic               wdErr
);

  // Period arithmetic is done one level wider than the counter so that
  // level*DEC_TICKS can never wrap and BASE_TICKS - level*DEC_TICKS is only
  // evaluated when it cannot underflow.
  localparam int PW = CNT_W + LEVEL_W;

  localparam logic [PW-1:0]      BASE_P  = PW'(BASE_TICKS);
  localparam logic [PW-1:0]      MIN_P   = PW'(MIN_TICKS);
  localparam logic [PW-1:0]      SPAN_P  = PW'(BASE_TICKS - MIN_TICKS);
  localparam logic [PW-1:0]      DEC_P   = PW'(DEC_TICKS);
  localparam logic [LEVEL_W-1:0] MAX_LVL = LEVEL_W'(MAX_LEVEL);

  // Elaboration-time sanity checks on the parameter set.
  if (BASE_TICKS >= (1 << CNT_W)) begin : g_chk_cnt_w
    $error("snake_step_timer: CNT_W too narrow to hold BASE_TICKS");
  end
  if (MAX_LEVEL >= (1 << LEVEL_W)) begin : g_chk_level_w
    $error("snake_step_timer: LEVEL_W too narrow to hold MAX_LEVEL");
  end
  if (MIN_TICKS < 1 || MIN_TICKS > BASE_TICKS) begin : g_chk_min
    $error("snake_step_timer: MIN_TICKS must be in 1..BASE_TICKS");
  end
  if (WD_CYCLES < 1) begin : g_chk_wd
    $error("snake_step_timer: WD_CYCLES must be positive");
  end

  // -------------------------------------------------------------------------
  // Synchroniser and rising-edge detector.
  // All three flops reset to 1 so that a slow clock which is already high
  // when reset is released does not look like a fresh rising edge.
  // Ticks are produced in every FSM state (the watchdog relies on them).
  // -------------------------------------------------------------------------
  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk50Mhz or posedge reset) begin
    if (reset) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      prev       <= 1'b1;
      tickStrobe <= 1'b0;
    end else begin
      sync1      <= slowClkIn;
      sync2      <= sync1;
      prev       <= sync2;
      tickStrobe <= sync2 & ~prev;
    end
  end

  // -------------------------------------------------------------------------
  // Step period for the current level, clamped at MIN_TICKS.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0]   counter;
  logic [PW-1:0]      level_scaled;
  logic [PW-1:0]      period;
  logic [PW-1:0]      count_inc;
  logic               step_due;
  logic [LEVEL_W-1:0] level_inc;

  assign level_scaled = PW'(level) * DEC_P;
  assign period       = (level_scaled >= SPAN_P) ? MIN_P : (BASE_P - level_scaled);
  assign count_inc    = PW'(counter) + PW'(1);
  // ">=" rather than "==" so a counter left above a freshly shortened period
  // fires on the next tick instead of wrapping all the way round.
  assign step_due     = (count_inc >= period);
  assign level_inc    = (level == MAX_LVL) ? level : (level + LEVEL_W'(1));

  // Asserted while the watchdog holds off step pulses.
  logic wd_block;

  // -------------------------------------------------------------------------
  // Watchdog (optional)
  // -------------------------------------------------------------------------
`ifdef STEP_WATCHDOG_EN
  localparam int              WD_W      = $clog2(WD_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT  = WD_W'(WD_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(WD_CYCLES - 1);

  logic [WD_W-1:0] wd_count;
  logic            wd_err;

  always_ff @(posedge clk50Mhz or posedge reset) begin
    if (reset) begin
      wd_count <= '0;
      wd_err   <= 1'b0;
    end else if (start || tickStrobe) begin
      wd_count <= '0;
      // Only start clears the error; a returning tick leaves it sticky.
      if (start) begin
        wd_err <= 1'b0;
      end
    end else if (wd_count != WD_LIMIT) begin
      wd_count <= wd_count + WD_W'(1);
      if (wd_count == WD_LAST) begin
        wd_err <= 1'b1;
      end
    end
  end

  assign wdErr    = wd_err;
  assign wd_block = wd_err;
`else
  assign wdErr    = 1'b0;
  assign wd_block = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Run/pause state machine with registered outputs.
  // Priority within a cycle: start > pauseToggle > speedUp. A tick arriving
  // in a start or pauseToggle cycle is dropped. speedUp and a tick in the
  // same cycle: the tick is compared against the old level's period.
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t state;

  always_ff @(posedge clk50Mhz or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      counter <= '0;
      level   <= '0;
      step    <= 1'b0;
      running <= 1'b0;
      paused  <= 1'b0;
    end else begin
      step <= 1'b0;
      if (start) begin
        state   <= ST_RUN;
        counter <= '0;
        level   <= '0;
        running <= 1'b1;
        paused  <= 1'b0;
      end else if (pauseToggle && (state != ST_IDLE)) begin
        if (state == ST_RUN) begin
          state   <= ST_PAUSE;
          running <= 1'b0;
          paused  <= 1'b1;
        end else begin
          state   <= ST_RUN;
          running <= 1'b1;
          paused  <= 1'b0;
        end
      end else begin
        if (speedUp && (state != ST_IDLE)) begin
          level <= level_inc;
        end
        // tickStrobe is itself a one-cycle pulse, so step can never be
        // high on two consecutive cycles.
        if ((state == ST_RUN) && tickStrobe) begin
          if (step_due) begin
            counter <= '0;
            step    <= ~wd_block;
          end else begin
            counter <= count_inc[CNT_W-1:0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_snake_step_timer.sv
module tb_snake_step_timer;
  localparam int BASE = 4;
  localparam int DEC  = 1;
  localparam int MINT = 2;
  localparam int MAXL = 3;
  localparam int LW   = 2;
  localparam int CW   = 4;
  localparam int WD   = 100;

  logic          clk50Mhz = 1'b0;
  logic          reset = 1'b1;
  logic          slowClkIn;
  logic          start = 1'b0;
  logic          pauseToggle = 1'b0;
  logic          speedUp = 1'b0;
  logic          tickStrobe;
  logic          step;
  logic [LW-1:0] level;
  logic          running;
  logic          paused;
  logic          wdErr;

  int tests = 0;
  int fails = 0;

  snake_step_timer #(
    .BASE_TICKS(BASE), .DEC_TICKS(DEC), .MIN_TICKS(MINT), .MAX_LEVEL(MAXL),
    .LEVEL_W(LW), .CNT_W(CW), .WD_CYCLES(WD)
  ) dut (
    .clk50Mhz(clk50Mhz), .reset(reset), .slowClkIn(slowClkIn),
    .start(start), .pauseToggle(pauseToggle), .speedUp(speedUp),
    .tickStrobe(tickStrobe), .step(step), .level(level),
    .running(running), .paused(paused), .wdErr(wdErr)
  );

  always #5 clk50Mhz = ~clk50Mhz;

  // Slow clock source: 0 = hold low, 1 = hold high, 2 = 20-cycle square wave.
  int slow_mode = 1;
  int slow_ph   = 0;
  always @(negedge clk50Mhz) begin
    if (slow_mode == 2) begin
      slow_ph   <= (slow_ph + 1) % 20;
      slowClkIn <= (((slow_ph + 1) % 20) >= 10);
    end else begin
      slow_ph   <= 0;
      slowClkIn <= (slow_mode == 1);
    end
  end

  // ------------------------------------------------------------------
  // Reference model. State: 0 idle, 1 run, 2 pause; counts kept as ints.
  // A rise of slowClkIn first sampled at edge k becomes a tick visible
  // after edge k+2, and that tick is acted on at edge k+3.
  // ------------------------------------------------------------------
  function automatic int period_of(int l);
    int p;
    p = l * DEC;
    return (p >= BASE - MINT) ? MINT : BASE - p;
  endfunction

  int   m_state, m_cnt, m_lvl, m_edge, m_rise;
  logic m_last, m_tick, m_step, m_wderr;
`ifdef STEP_WATCHDOG_EN
  int   m_wd;
`endif

  always @(posedge clk50Mhz or posedge reset) begin
    if (reset) begin
      m_state <= 0; m_cnt <= 0; m_lvl <= 0; m_edge <= 0; m_rise <= -100;
      m_last <= 1'b1; m_tick <= 1'b0; m_step <= 1'b0; m_wderr <= 1'b0;
`ifdef STEP_WATCHDOG_EN
      m_wd <= 0;
`endif
    end else begin
      m_edge <= m_edge + 1;
      m_last <= slowClkIn;
      if (slowClkIn && !m_last) m_rise <= m_edge;
      m_tick <= (m_edge == m_rise + 2);
      m_step <= 1'b0;
      if (start) begin
        m_state <= 1; m_cnt <= 0; m_lvl <= 0;
      end else if (pauseToggle && m_state != 0) begin
        m_state <= (m_state == 1) ? 2 : 1;
      end else begin
        if (speedUp && m_state != 0 && m_lvl < MAXL) m_lvl <= m_lvl + 1;
        if (m_state == 1 && m_tick) begin
          if (m_cnt + 1 >= period_of(m_lvl)) begin
            m_cnt  <= 0;
            m_step <= !m_wderr;
          end else begin
            m_cnt <= m_cnt + 1;
          end
        end
      end
`ifdef STEP_WATCHDOG_EN
      if (start || m_tick) begin
        m_wd <= 0;
        if (start) m_wderr <= 1'b0;
      end else if (m_wd < WD) begin
        m_wd <= m_wd + 1;
        if (m_wd + 1 == WD) m_wderr <= 1'b1;
      end
`endif
    end
  end

  logic [LW+4:0] dut_vec;
  logic [LW+4:0] m_vec;
  assign dut_vec = {tickStrobe, step, running, paused, wdErr, level};
  assign m_vec   = {m_tick, m_step, (m_state == 1), (m_state == 2), m_wderr, LW'(m_lvl)};

  // ------------------------------------------------------------------
  task automatic test_reset();
    int seen;
    logic found;
    slow_mode = 1; reset = 1'b1;
    repeat (4) @(negedge clk50Mhz);
    reset = 1'b0;
    @(negedge clk50Mhz);
    tests++; if (tickStrobe !== 1'b0) begin fails++; $display("FAIL reset_tick: got %b want 0", tickStrobe); end
    tests++; if (step !== 1'b0) begin fails++; $display("FAIL reset_step: got %b want 0", step); end
    tests++; if (running !== 1'b0) begin fails++; $display("FAIL reset_running: got %b want 0", running); end
    tests++; if (paused !== 1'b0) begin fails++; $display("FAIL reset_paused: got %b want 0", paused); end
    tests++; if (level !== '0) begin fails++; $display("FAIL reset_level: got %0d want 0", level); end
    tests++; if (wdErr !== 1'b0) begin fails++; $display("FAIL reset_wderr: got %b want 0", wdErr); end
    seen = 0;
    repeat (15) begin
      @(negedge clk50Mhz);
      tests++; if (dut_vec !== m_vec) begin fails++; $display("FAIL reset_model: got %b want %b", dut_vec, m_vec); end
      if (tickStrobe) seen++;
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL reset_false_tick: got %0d ticks want 0", seen); end
    slow_mode = 2;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk50Mhz);
      tests++; if (dut_vec !== m_vec) begin fails++; $display("FAIL reset_model2: got %b want %b", dut_vec, m_vec); end
      if (tickStrobe) found = 1'b1;
    end
    tests++; if (!found) begin fails++; $display("FAIL reset_first_tick: got none want a tick"); end
    $display("[TB] reset: done");
  endtask

  task automatic test_run();
    int ticks, steps, ext;
    logic prev_t;
    ticks = 0; steps = 0; ext = 0; prev_t = 1'b0;
    repeat ($urandom_range(1, 19)) @(negedge clk50Mhz);
    start = 1'b1; @(negedge clk50Mhz); start = 1'b0;
    for (int c = 0; c < 400 && ext < 3; c++) begin
      tests++; if (dut_vec !== m_vec) begin fails++; $display("FAIL run_model: got %b want %b", dut_vec, m_vec); end
      if (step) begin
        steps++;
        tests++;
        if (!prev_t || ticks != 4 * steps) begin
          fails++; $display("FAIL run_step_pos: step after tick %0d (prev_tick %b) want tick %0d", ticks, prev_t, 4 * steps);
        end
      end
      prev_t = tickStrobe;
      if (tickStrobe) ticks++;
      if (ticks >= 8) ext++;
      @(negedge clk50Mhz);
    end
    tests++; if (ext < 3) begin fails++; $display("FAIL run_timeout: got %0d ticks want 8", ticks); end
    tests++; if (steps != 2) begin fails++; $display("FAIL run_steps: got %0d want 2", steps); end
    tests++; if (running !== 1'b1) begin fails++; $display("FAIL run_running: got %b want 1", running); end
    $display("[TB] run: %0d ticks %0d steps", ticks, steps);
  endtask

  task automatic test_speed();
    int ticks, steps, ext, exp_l;
    logic prev_t;
    for (int i = 0; i < 9; i++) begin
      repeat ($urandom_range(1, 5)) begin
        @(negedge clk50Mhz);
        tests++; if (dut_vec !== m_vec) begin fails++; $display("FAIL speed_model: got %b want %b", dut_vec, m_vec); end
      end
      speedUp = 1'b1; @(negedge clk50Mhz); speedUp = 1'b0;
      exp_l = (i + 1 > MAXL) ? MAXL : i + 1;
      tests++; if (level !== exp_l[LW-1:0]) begin fails++; $display("FAIL speed_level: got %0d want %0d", level, exp_l); end
    end
    // Period is now 2: eight ticks give four steps whatever the counter was.
    ticks = 0; steps = 0; ext = 0; prev_t = 1'b0;
    for (int c = 0; c < 400 && ext < 3; c++) begin
      tests++; if (dut_vec !== m_vec) begin fails++; $display("FAIL speed_model2: got %b want %b", dut_vec, m_vec); end
      if (step && prev_t) steps++;
      prev_t = tickStrobe;
      if (tickStrobe) ticks++;
      if (ticks >= 8) ext++;
      @(negedge clk50Mhz);
    end
    tests++; if (steps != 4) begin fails++; $display("FAIL speed_steps: got %0d want 4", steps); end
    $display("[TB] speed: level %0d, %0d steps in %0d ticks", level, steps, ticks);
  endtask

  task automatic test_pause();
    int ticks, steps;
    logic prev_t, found;
    repeat ($urandom_range(1, 19)) @(negedge clk50Mhz);
    start = 1'b1; @(negedge clk50Mhz); start = 1'b0;
    ticks = 0;
    for (int c = 0; c < 200 && ticks < 2; c++) begin
      tests++; if (dut_vec !== m_vec) begin fails++; $display("FAIL pause_model: got %b want %b", dut_vec, m_vec); end
      if (tickStrobe) ticks++;
      @(negedge clk50Mhz);
    end
    pauseToggle = 1'b1; @(negedge clk50Mhz); pauseToggle = 1'b0;
    tests++; if ({running, paused} !== 2'b01) begin fails++; $display("FAIL pause_enter: got run/pause %b%b want 01", running, paused); end
    ticks = 0; steps = 0;
    for (int c = 0; c < 300 && ticks < 5; c++) begin
      tests++; if (dut_vec !== m_vec) begin fails++; $display("FAIL pause_model2: got %b want %b", dut_vec, m_vec); end
      if (step) steps++;
      if (tickStrobe) ticks++;
      @(negedge clk50Mhz);
    end
    tests++; if (steps != 0 || ticks != 5) begin fails++; $display("FAIL pause_hold: got %0d steps %0d ticks want 0 steps 5 ticks", steps, ticks); end
    pauseToggle = 1'b1; @(negedge clk50Mhz); pauseToggle = 1'b0;
    tests++; if ({running, paused} !== 2'b10) begin fails++; $display("FAIL pause_resume: got run/pause %b%b want 10", running, paused); end
    ticks = 0; prev_t = 1'b0; found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      tests++; if (dut_vec !== m_vec) begin fails++; $display("FAIL pause_model3: got %b want %b", dut_vec, m_vec); end
      if (step) begin
        found = 1'b1;
        tests++;
        if (!prev_t || ticks != 2) begin fails++; $display("FAIL pause_resume_step: step after tick %0d want tick 2", ticks); end
      end
      prev_t = tickStrobe;
      if (tickStrobe) ticks++;
      @(negedge clk50Mhz);
    end
    tests++; if (!found) begin fails++; $display("FAIL pause_no_step: got none want a step"); end
    $display("[TB] pause: resume step after %0d ticks", ticks);
  endtask

  task automatic test_start_in_pause();
    int ticks;
    logic prev_t, found;
    repeat (2) begin
      speedUp = 1'b1; @(negedge clk50Mhz); speedUp = 1'b0;
      @(negedge clk50Mhz);
    end
    pauseToggle = 1'b1; @(negedge clk50Mhz); pauseToggle = 1'b0;
    tests++; if ({paused, level} !== {1'b1, LW'(2)}) begin fails++; $display("FAIL sip_setup: got paused %b level %0d want 1 2", paused, level); end
    for (int c = 0; c < 60 && !tickStrobe; c++) @(negedge clk50Mhz);
    tests++; if (tickStrobe !== 1'b1) begin fails++; $display("FAIL sip_tick_wait: got %b want 1", tickStrobe); end
    start = 1'b1; pauseToggle = 1'b1; @(negedge clk50Mhz); start = 1'b0; pauseToggle = 1'b0;
    tests++; if ({running, paused, level} !== {2'b10, LW'(0)}) begin
      fails++; $display("FAIL sip_state: got run %b pause %b level %0d want 1 0 0", running, paused, level);
    end
    ticks = 0; prev_t = 1'b0; found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      tests++; if (dut_vec !== m_vec) begin fails++; $display("FAIL sip_model: got %b want %b", dut_vec, m_vec); end
      if (step) begin
        found = 1'b1;
        tests++;
        if (!prev_t || ticks != 4) begin fails++; $display("FAIL sip_step: step after tick %0d want tick 4", ticks); end
      end
      prev_t = tickStrobe;
      if (tickStrobe) ticks++;
      @(negedge clk50Mhz);
    end
    tests++; if (!found) begin fails++; $display("FAIL sip_no_step: got none want a step"); end
    $display("[TB] start_in_pause: first step after %0d ticks", ticks);
  endtask

  task automatic test_watchdog();
    int since, err_at, steps;
    for (int c = 0; c < 60 && !tickStrobe; c++) @(negedge clk50Mhz);
    slow_mode = 0;
    since = 0; err_at = -1;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk50Mhz);
      since++;
      tests++; if (dut_vec !== m_vec) begin fails++; $display("FAIL wd_model: got %b want %b", dut_vec, m_vec); end
      if (wdErr && err_at < 0) err_at = since;
    end
`ifdef STEP_WATCHDOG_EN
    // The counter clears on the edge after the observed tick, then needs 100
    // counting edges, so the error shows 101 falling edges after the tick.
    tests++; if (err_at != 101) begin fails++; $display("FAIL wd_set_time: got %0d want 101", err_at); end
    slow_mode = 2; steps = 0;
    repeat (120) begin
      @(negedge clk50Mhz);
      tests++; if (dut_vec !== m_vec) begin fails++; $display("FAIL wd_model2: got %b want %b", dut_vec, m_vec); end
      if (step) steps++;
    end
    tests++; if (steps != 0 || wdErr !== 1'b1) begin fails++; $display("FAIL wd_block: got %0d steps wdErr %b want 0 1", steps, wdErr); end
    start = 1'b1; @(negedge clk50Mhz); start = 1'b0;
    tests++; if (wdErr !== 1'b0) begin fails++; $display("FAIL wd_clear: got %b want 0", wdErr); end
    steps = 0;
    repeat (120) begin
      @(negedge clk50Mhz);
      tests++; if (dut_vec !== m_vec) begin fails++; $display("FAIL wd_model3: got %b want %b", dut_vec, m_vec); end
      if (step) steps++;
    end
    tests++; if (steps == 0) begin fails++; $display("FAIL wd_resume: got 0 steps want at least 1"); end
`else
    tests++; if (err_at != -1 || wdErr !== 1'b0) begin fails++; $display("FAIL wd_tied: got wdErr %b want 0", wdErr); end
    slow_mode = 2;
    steps = 0;
`endif
    $display("[TB] watchdog: err_at %0d, steps %0d", err_at, steps);
  endtask

  task automatic test_random();
    logic prev_s;
    prev_s = 1'b0;
    slow_mode = 2;
    for (int c = 0; c < 800; c++) begin
      tests++; if (dut_vec !== m_vec) begin fails++; $display("FAIL random_model: cycle %0d got %b want %b", c, dut_vec, m_vec); end
      tests++; if (step && prev_s) begin fails++; $display("FAIL random_back_to_back: cycle %0d got step 11 want no 2-cycle step", c); end
      prev_s      = step;
      start       = ($urandom_range(0, 99) == 0);
      pauseToggle = ($urandom_range(0, 19) == 0);
      speedUp     = ($urandom_range(0, 14) == 0);
      @(negedge clk50Mhz);
    end
    start = 1'b0; pauseToggle = 1'b0; speedUp = 1'b0;
    $display("[TB] random: 800 cycles");
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_run();
    test_speed();
    test_pause();
    test_start_in_pause();
    test_watchdog();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
